// File: rtl/aes_inv_ctrl.sv
// aes_inv_ctrl: sequencer in front of a 128-bit AES inverse cipher core.
// Accepts a key, waits out round-key expansion, then feeds one ciphertext
// block at a time to the core and holds each plaintext until consumed.
// Optional RUN watchdog: define AES_INV_CTRL_TIMEOUT_EN.
module aes_inv_ctrl #(
    parameter int unsigned KEY_WAIT = 12,
    parameter int unsigned TIMEOUT  = 31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    input  logic         ct_valid,
    output logic         ct_ready,
    input  logic [127:0] ct_data,
    output logic         pt_valid,
    input  logic         pt_ready,
    output logic [127:0] pt_data,
    output logic         key_ok,
    output logic         busy,
    output logic         err,
    output logic         core_kld,
    output logic [127:0] core_key,
    output logic         core_ld,
    output logic [127:0] core_text_in,
    input  logic         core_done,
    input  logic [127:0] core_text_out
);

    localparam logic [3:0] WaitInit = 4'(KEY_WAIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StKload,
        StKwait,
        StReady,
        StLd,
        StRun,
        StOut
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] key_q, key_d;
    logic [127:0] text_q, text_d;
    logic [127:0] pt_q, pt_d;
    logic         key_ok_q, key_ok_d;
    logic         key_hs, ct_hs;

`ifdef AES_INV_CTRL_TIMEOUT_EN
    localparam logic [4:0] WdLast = 5'(TIMEOUT - 1);
    logic [4:0] wd_q, wd_d;
    logic       err_q, err_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    assign key_hs = key_valid & key_ready;
    assign ct_hs  = ct_valid & ct_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            key_q    <= '0;
            text_q   <= '0;
            pt_q     <= '0;
            key_ok_q <= 1'b0;
`ifdef AES_INV_CTRL_TIMEOUT_EN
            wd_q     <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            text_q   <= text_d;
            pt_q     <= pt_d;
            key_ok_q <= key_ok_d;
`ifdef AES_INV_CTRL_TIMEOUT_EN
            wd_q     <= wd_d;
            err_q    <= err_d;
`endif
        end
    end

    // Next-state and register updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        text_d   = text_q;
        pt_d     = pt_q;
        key_ok_d = key_ok_q;
`ifdef AES_INV_CTRL_TIMEOUT_EN
        wd_d     = wd_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (key_hs) begin
                    key_d   = key_in;
                    state_d = StKload;
                end
            end
            StKload: begin
                cnt_d   = WaitInit;
                state_d = StKwait;
            end
            StKwait: begin
                // Leave as the counter lands on zero so key_ok rises KEY_WAIT+1
                // cycles after the key handshake.
                if (cnt_q <= 4'd1) begin
                    cnt_d    = '0;
                    key_ok_d = 1'b1;
                    state_d  = StReady;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StReady: begin
                if (key_hs) begin
                    key_d    = key_in;
                    key_ok_d = 1'b0;
                    state_d  = StKload;
                end else if (ct_hs) begin
                    text_d  = ct_data;
                    state_d = StLd;
                end
            end
            StLd: begin
`ifdef AES_INV_CTRL_TIMEOUT_EN
                wd_d = '0;
`endif
                state_d = StRun;
            end
            StRun: begin
                // core_done beats a coincident timeout
                if (core_done) begin
                    pt_d    = core_text_out;
                    state_d = StOut;
                end
`ifdef AES_INV_CTRL_TIMEOUT_EN
                else if (wd_q == WdLast) begin
                    err_d   = 1'b1;
                    state_d = StReady;
                end else begin
                    wd_d = wd_q + 5'd1;
                end
`endif
            end
            StOut: begin
                if (pt_ready) begin
                    state_d = StReady;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake, strobe and status outputs decoded from state
    always_comb begin
        key_ready = 1'b0;
        ct_ready  = 1'b0;
        core_kld  = 1'b0;
        core_ld   = 1'b0;
        pt_valid  = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            // Gated by rst so every output reads 0 while reset is held.
            StIdle:  key_ready = rst;
            StReady: begin
                key_ready = rst;
                ct_ready  = ~key_valid;
            end
            StKload: begin
                core_kld = 1'b1;
                busy     = 1'b1;
            end
            StKwait: busy = 1'b1;
            StLd: begin
                core_ld = 1'b1;
                busy    = 1'b1;
            end
            StRun:   busy = 1'b1;
            StOut: begin
                pt_valid = 1'b1;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    assign key_ok       = key_ok_q;
    assign core_key     = key_q;
    assign core_text_in = text_q;
    assign pt_data      = pt_q;
`ifdef AES_INV_CTRL_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
